// File: rtl/spdif_tx_scheduler_if.sv
// rtl/spdif_tx_scheduler_if.sv - Avalon-MM control port bundle for spdif_tx_scheduler
interface spdif_tx_scheduler_if;
  logic [2:0]  avs_ctrl_address;
  logic [31:0] avs_ctrl_writedata;
  logic [3:0]  avs_ctrl_byteenable;
  logic        avs_ctrl_write;
  logic        avs_ctrl_read;
  logic [31:0] avs_ctrl_readdata;
  logic        avs_ctrl_waitrequest;

  modport master (
    output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
    output avs_ctrl_write, avs_ctrl_read,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest
  );

  modport slave (
    input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
    input  avs_ctrl_write, avs_ctrl_read,
    output avs_ctrl_readdata, avs_ctrl_waitrequest
  );
endinterface

// File: rtl/spdif_tx_scheduler.sv
// rtl/spdif_tx_scheduler.sv - PCM FIFO + IEC60958 subframe/frame/block scheduler with BMC output
// Optional irq output and CTRL[1] storage enabled by defining SPDIF_TX_IRQ_EN.
module spdif_tx_scheduler #(
  parameter int          CLK_DIV    = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BLOCK_ID   = 32'hEA680004
) (
  input  logic                 csi_MCLK_clk,
  input  logic                 rsi_MRST_reset,
  spdif_tx_scheduler_if.slave  ctrl,
`ifdef SPDIF_TX_IRQ_EN
  output logic                 ins_irq_irq,
`endif
  output logic                 SPDIF_OUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef SPDIF_TX_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   chstat_q, chstat_d;
  logic          und_q, und_d, ovf_q, ovf_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    cnt_q, cnt_d, frame_q, frame_d;
  logic [5:0]    hc_q, hc_d;
  logic          side_q, side_d, pre_inv_q, pre_inv_d, out_q, out_d;
  logic [31:0]   word_q, word_d, rdata_q, rdata_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic        en, tick, full, empty, do_load, do_shift, pop, push, push_ok;
  logic        wr_ctrl, wr_stat, wr_cs, c_bit;
  logic [23:0] sample;
  logic [7:0]  pre_pat;
  logic [31:0] lvl_w, status_w;

  assign en      = ctrl_q[0];
  assign tick    = en && (cnt_q == 8'(CLK_DIV - 1));
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign push    = ctrl.avs_ctrl_write && (ctrl.avs_ctrl_address == 3'd3);
  assign wr_ctrl = ctrl.avs_ctrl_write && (ctrl.avs_ctrl_address == 3'd1);
  assign wr_stat = ctrl.avs_ctrl_write && (ctrl.avs_ctrl_address == 3'd2);
  assign wr_cs   = ctrl.avs_ctrl_write && (ctrl.avs_ctrl_address == 3'd4);
  assign lvl_w   = 32'(level_q);
  assign status_w = {20'd0, full, empty, ovf_q, und_q, 3'd0, lvl_w[4:0]};

  assign ctrl.avs_ctrl_readdata    = rdata_q;
  assign ctrl.avs_ctrl_waitrequest = 1'b0;
  assign SPDIF_OUT                 = out_q;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (tick && hc_q == 6'd63) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  always_comb begin
    do_load  = en && (state_q == S_LOAD);
    do_shift = en && (state_q == S_SHIFT) && tick;
    pop      = do_load && !empty;
  end

  // A full FIFO still accepts a push in the same cycle a pop frees a slot.
  assign push_ok = push && (!full || pop);
  assign sample  = pop ? mem_q[rd_ptr_q] : 24'h0;
  assign c_bit   = (frame_q < 8'd32) ? chstat_q[frame_q[4:0]] : 1'b0;
  assign pre_pat = side_q ? 8'b11100100 : ((frame_q == 8'd0) ? 8'b11101000 : 8'b11100010);

  always_comb begin
    ctrl_d    = ctrl_q;
    chstat_d  = chstat_q;
    und_d     = und_q;
    ovf_d     = ovf_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    cnt_d     = tick ? 8'd0 : cnt_q + 8'd1;
    frame_d   = frame_q;
    hc_d      = hc_q;
    side_d    = side_q;
    pre_inv_d = pre_inv_q;
    out_d     = out_q;
    word_d    = word_q;
    rdata_d   = rdata_q;

    if (wr_ctrl && ctrl.avs_ctrl_byteenable[0]) ctrl_d = ctrl.avs_ctrl_writedata[2:0] & CTRL_MASK;
    if (wr_cs)
      for (int b = 0; b < 4; b++)
        if (ctrl.avs_ctrl_byteenable[b]) chstat_d[8*b +: 8] = ctrl.avs_ctrl_writedata[8*b +: 8];
    if (wr_stat && ctrl.avs_ctrl_writedata[8]) und_d = 1'b0;
    if (wr_stat && ctrl.avs_ctrl_writedata[9]) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
    if (do_load && empty) und_d = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (do_load) begin
      word_d    = {^{c_bit, ctrl_q[2], sample}, c_bit, 1'b0, ctrl_q[2], sample, 4'd0};
      pre_inv_d = out_q;
      hc_d      = 6'd0;
    end
    // Preamble half-cells are absolute levels; data cells toggle relative to the line.
    if (do_shift) begin
      if (hc_q < 6'd8)  out_d = pre_pat[3'd7 - hc_q[2:0]] ^ pre_inv_q;
      else if (!hc_q[0]) out_d = ~out_q;
      else               out_d = word_q[hc_q[5:1]] ? ~out_q : out_q;
      hc_d = hc_q + 6'd1;
      if (hc_q == 6'd63) begin
        side_d = ~side_q;
        if (side_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
      end
    end

    if (!en) begin
      cnt_d   = 8'd0;
      frame_d = 8'd0;
      hc_d    = 6'd0;
      side_d  = 1'b0;
      out_d   = 1'b0;
    end

    if (ctrl.avs_ctrl_read) begin
      case (ctrl.avs_ctrl_address)
        3'd0:    rdata_d = BLOCK_ID;
        3'd1:    rdata_d = {29'd0, ctrl_q};
        3'd2:    rdata_d = status_w;
        3'd4:    rdata_d = chstat_q;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      ctrl_q <= '0;  chstat_q <= '0;  und_q <= 1'b0;  ovf_q <= 1'b0;
      rd_ptr_q <= '0;  wr_ptr_q <= '0;  level_q <= '0;  cnt_q <= '0;
      frame_q <= '0;  hc_q <= '0;  side_q <= 1'b0;  pre_inv_q <= 1'b0;
      out_q <= 1'b0;  word_q <= '0;  rdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;  chstat_q <= chstat_d;  und_q <= und_d;  ovf_q <= ovf_d;
      rd_ptr_q <= rd_ptr_d;  wr_ptr_q <= wr_ptr_d;  level_q <= level_d;  cnt_q <= cnt_d;
      frame_q <= frame_d;  hc_q <= hc_d;  side_q <= side_d;  pre_inv_q <= pre_inv_d;
      out_q <= out_d;  word_q <= word_d;  rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= ctrl.avs_ctrl_writedata[23:0];
  end

`ifdef SPDIF_TX_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d       = ctrl_q[1] & (und_q | (level_q <= LW'(FIFO_DEPTH / 2)));
  assign ins_irq_irq = irq_q;
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) irq_q <= 1'b0;
    else                irq_q <= irq_d;
  end
`endif
endmodule

// File: tb/tb_spdif_tx_scheduler.sv
// tb/tb_spdif_tx_scheduler.sv - randomized self-checking bench for spdif_tx_scheduler
module tb_spdif_tx_scheduler;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spdif;
  logic irq;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [23:0] smp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  spdif_tx_scheduler_if bus ();

  spdif_tx_scheduler #(.CLK_DIV(DIV), .FIFO_DEPTH(16), .BLOCK_ID(32'hEA680004)) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .ctrl           (bus),
`ifdef SPDIF_TX_IRQ_EN
    .ins_irq_irq    (irq),
`endif
    .SPDIF_OUT      (spdif)
  );

`ifndef SPDIF_TX_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  // Expected 64 half-cell line levels of one subframe, index 0 transmitted first.
  function automatic logic [63:0] model_sub(input logic [23:0] s, input bit right, input int frame,
                                            input bit v, input logic [31:0] cs, input bit prev);
    logic [31:0] slots;
    logic [7:0]  pre;
    logic [63:0] h;
    logic        lvl;
    slots = '0;
    slots[27:4] = s;
    slots[28] = v;
    slots[30] = (frame < 32) ? cs[frame] : 1'b0;
    slots[31] = ^slots[30:4];
    pre = right ? 8'b11100100 : ((frame == 0) ? 8'b11101000 : 8'b11100010);
    if (prev) pre = ~pre;
    for (int i = 0; i < 8; i++) h[i] = pre[7-i];
    lvl = h[7];
    for (int k = 4; k < 32; k++) begin
      lvl = ~lvl;
      h[2*k] = lvl;
      if (slots[k]) lvl = ~lvl;
      h[2*k+1] = lvl;
    end
    return h;
  endfunction

  function automatic logic [7:0] pre_of(input logic [63:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[i];
    return r;
  endfunction

  task automatic build_expected(input int n, input logic [31:0] cs, input bit v);
    int frame = 0;
    bit right = 0;
    bit prev = 0;
    logic [63:0] x;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      x = model_sub((i < smp_q.size()) ? smp_q[i] : 24'h0, right, frame, v, cs, prev);
      exp_q.push_back(x);
      prev = x[63];
      if (right) frame = (frame + 1) % 192;
      right = !right;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic avs_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.avs_ctrl_address = a;
    bus.avs_ctrl_writedata = d;
    bus.avs_ctrl_byteenable = be;
    bus.avs_ctrl_write = 1'b1;
    @(negedge clk);
    bus.avs_ctrl_write = 1'b0;
  endtask

  task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_ctrl_address = a;
    bus.avs_ctrl_read = 1'b1;
    @(negedge clk);
    bus.avs_ctrl_read = 1'b0;
    d = bus.avs_ctrl_readdata;
  endtask

  task automatic push_sample(input logic [23:0] s);
    logic [31:0] junk = $urandom;
    avs_write(3'd3, {junk[7:0], s}, junk[11:8]);
  endtask

  task automatic wait_rise(output bit ok);
    int t = 0;
    while (spdif !== 1'b1 && t < 64 * DIV + 40) begin
      @(negedge clk);
      t++;
    end
    ok = (spdif === 1'b1);
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL stream_start: no first preamble edge within %0d cycles", t);
    end
  endtask

  task automatic capture(input int n);
    bit ok;
    logic [63:0] h;
    obs_q.delete();
    wait_rise(ok);
    for (int i = 0; i < n; i++) begin
      h = '0;
      if (ok)
        for (int j = 0; j < 64; j++) begin
          h[j] = spdif;
          repeat (DIV) @(negedge clk);
        end
      obs_q.push_back(h);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [2:0] addrs[5] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd6};
    logic [31:0] exps[5] = '{32'hEA680004, 32'h00000400, 32'h0, 32'h0, 32'h0};
    do_reset();
    tests_run++;
    if (spdif !== 1'b0 || bus.avs_ctrl_waitrequest !== 1'b0 || bus.avs_ctrl_readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: out=%b wait=%b rd=%h irq=%b, want 0/0/0/0", spdif,
               bus.avs_ctrl_waitrequest, bus.avs_ctrl_readdata, irq);
    end
    for (int i = 0; i < 5; i++) begin
      avs_read(addrs[i], d);
      tests_run++;
      if (d !== exps[i]) begin
        tests_failed++;
        $display("FAIL reset_read_a%0d: got %h want %h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_fifo_flags();
    logic [31:0] d;
    int n = $urandom_range(1, 15);
    do_reset();
    for (int i = 0; i < n; i++) push_sample(24'($urandom));
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'(n)) begin
      tests_failed++;
      $display("FAIL fifo_level_%0d: got %h want %h", n, d, 32'(n));
    end
    for (int i = n; i < 17; i++) push_sample(24'($urandom));
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000A10) begin
      tests_failed++;
      $display("FAIL fifo_overflow: got %h want 00000a10", d);
    end
    avs_write(3'd2, 32'h200, 4'hF);
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000810) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %h want 00000810", d);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, cs, cs2;
    logic [3:0] be;
    logic [2:0] cmask;
    do_reset();
    cs = $urandom;
    avs_write(3'd4, cs, 4'hF);
    avs_read(3'd4, d);
    tests_run++;
    if (d !== cs) begin
      tests_failed++;
      $display("FAIL chstat_rw: got %h want %h", d, cs);
    end
    cs2 = $urandom;
    be = 4'($urandom);
    avs_write(3'd4, cs2, be);
    for (int b = 0; b < 4; b++) if (be[b]) cs[8*b +: 8] = cs2[8*b +: 8];
    avs_read(3'd4, d);
    tests_run++;
    if (d !== cs) begin
      tests_failed++;
      $display("FAIL chstat_byteen_%h: got %h want %h", be, d, cs);
    end
    avs_write(3'd1, 32'h6, 4'h0);
    avs_read(3'd1, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL ctrl_be0: got %h want 0", d);
    end
`ifdef SPDIF_TX_IRQ_EN
    cmask = 3'b110;
`else
    cmask = 3'b100;
`endif
    avs_write(3'd1, 32'hFFFF_FFF6, 4'h1);
    avs_read(3'd1, d);
    tests_run++;
    if (d !== {29'd0, cmask}) begin
      tests_failed++;
      $display("FAIL ctrl_rw: got %h want %h", d, {29'd0, cmask});
    end
    avs_write(3'd5, 32'hFFFF_FFFF, 4'hF);
    avs_read(3'd5, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_read: got %h want 0", d);
    end
  endtask

  task automatic test_spec_vector();
    do_reset();
    smp_q = '{24'h000001, 24'h800000};
    foreach (smp_q[i]) push_sample(smp_q[i]);
    avs_write(3'd1, 32'h1, 4'hF);
    capture(2);
    build_expected(2, 32'h0, 1'b0);
    tests_run++;
    if (pre_of(obs_q[0]) !== 8'b11101000 || (obs_q[0][8] ^ obs_q[0][9]) !== 1'b1 || (obs_q[0][62] ^ obs_q[0][63]) !== 1'b1) begin
      tests_failed++;
      $display("FAIL vec_left: pre=%b lsb=%b par=%b want 11101000/1/1", pre_of(obs_q[0]),
               obs_q[0][8] ^ obs_q[0][9], obs_q[0][62] ^ obs_q[0][63]);
    end
    tests_run++;
    if (pre_of(obs_q[1]) !== 8'b11100100 || (obs_q[1][54] ^ obs_q[1][55]) !== 1'b1) begin
      tests_failed++;
      $display("FAIL vec_right: pre=%b bit27=%b want 11100100/1", pre_of(obs_q[1]), obs_q[1][54] ^ obs_q[1][55]);
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL vec_sub%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    avs_write(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_random_stream();
    logic [31:0] cs, d;
    bit v;
    int k;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      k = $urandom_range(3, 16);
      cs = $urandom;
      v = bit'($urandom_range(0, 1));
      smp_q.delete();
      for (int i = 0; i < k; i++) smp_q.push_back(24'($urandom));
      foreach (smp_q[i]) push_sample(smp_q[i]);
      avs_write(3'd4, cs, 4'hF);
      avs_write(3'd1, {29'd0, v, 2'b01}, 4'hF);
      capture(k + 2);
      build_expected(k + 2, cs, v);
      for (int i = 0; i < k + 2; i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rand%0d_sub%0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      avs_read(3'd2, d);
      tests_run++;
      if (d !== 32'h00000500) begin
        tests_failed++;
        $display("FAIL rand%0d_underrun: got %h want 00000500", it, d);
      end
      avs_write(3'd1, 32'h0, 4'hF);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d;
    do_reset();
    smp_q.delete();
    avs_write(3'd1, 32'h3, 4'hF);
    capture(2);
    build_expected(2, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL underrun_sub%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000500) begin
      tests_failed++;
      $display("FAIL underrun_flag: got %h want 00000500", d);
    end
`ifdef SPDIF_TX_IRQ_EN
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_irq: got %b want 1", irq);
    end
`endif
    avs_write(3'd1, 32'h0, 4'hF);
    @(negedge clk);
    avs_write(3'd2, 32'h100, 4'hF);
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000400) begin
      tests_failed++;
      $display("FAIL underrun_clear: got %h want 00000400", d);
    end
  endtask

  task automatic test_block();
    bit c, want;
    do_reset();
    smp_q.delete();
    avs_write(3'd4, 32'h4, 4'hF);
    avs_write(3'd1, 32'h1, 4'hF);
    capture(390);
    build_expected(390, 32'h4, 1'b0);
    for (int i = 0; i < 390; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL block_sub%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      c = obs_q[i][60] ^ obs_q[i][61];
      want = ((i / 2) == 2) || ((i / 2) == 194);
      tests_run++;
      if (c !== want) begin
        tests_failed++;
        $display("FAIL block_cbit_f%0d: got %b want %b", i / 2, c, want);
      end
    end
    tests_run++;
    if (pre_of(obs_q[384]) !== 8'b11101000) begin
      tests_failed++;
      $display("FAIL block_wrap_B: got %b want 11101000", pre_of(obs_q[384]));
    end
    avs_write(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bit ok;
    int highs = 0;
    do_reset();
    smp_q.delete();
    for (int i = 0; i < 4; i++) smp_q.push_back(24'($urandom));
    foreach (smp_q[i]) push_sample(smp_q[i]);
    avs_write(3'd1, 32'h1, 4'hF);
    wait_rise(ok);
    repeat (20 * DIV) @(negedge clk);
    avs_write(3'd1, 32'h0, 4'hF);
    tests_run++;
    if (spdif !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_out: got %b want 0", spdif);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spdif !== 1'b0) highs++;
    end
    tests_run++;
    if (highs != 0) begin
      tests_failed++;
      $display("FAIL disable_quiet: got %0d high cycles want 0", highs);
    end
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000003) begin
      tests_failed++;
      $display("FAIL disable_fifo_kept: got %h want 00000003", d);
    end
    void'(smp_q.pop_front());
    avs_write(3'd1, 32'h1, 4'hF);
    capture(2);
    build_expected(2, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL reenable_sub%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    avs_write(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_midreset();
    logic [31:0] d;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) push_sample(24'($urandom));
    avs_write(3'd1, 32'h1, 4'hF);
    wait_rise(ok);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (spdif !== 1'b0 || bus.avs_ctrl_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_async: out=%b rd=%h want 0/0", spdif, bus.avs_ctrl_readdata);
    end
    @(negedge clk);
    rst = 1'b0;
    avs_read(3'd2, d);
    tests_run++;
    if (d !== 32'h00000400) begin
      tests_failed++;
      $display("FAIL midreset_flush: got %h want 00000400", d);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (spdif !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_idle: got %b want 0", spdif);
    end
  endtask

  initial begin
    bus.avs_ctrl_address = '0;
    bus.avs_ctrl_writedata = '0;
    bus.avs_ctrl_byteenable = '0;
    bus.avs_ctrl_write = 1'b0;
    bus.avs_ctrl_read = 1'b0;
    @(negedge clk);
    test_reset();
    test_fifo_flags();
    test_regs();
    test_spec_vector();
    test_random_stream();
    test_underrun();
    test_disable();
    test_midreset();
    test_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
